// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift register slice: default frame width,
// strobe-pair selection encoding and the frame state encoding.
package spi_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic SEL_SCLK0 = 1'b0;
    localparam logic SEL_SCLK  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2
    } state_t;

    // Choose the strobe of the pair selected by the latched mode.
    function automatic logic pick_strobe(input logic sel, input logic stb_sclk, input logic stb_sclk0);
        logic stb;
        case (sel)
            SEL_SCLK:  stb = stb_sclk;
            SEL_SCLK0: stb = stb_sclk0;
            default:   stb = 1'b0;
        endcase
        return stb;
    endfunction

endpackage

// File: rtl/spi_bit_index.sv
// Maps a frame bit count onto the shift-register bit position for the
// latched bit order, and flags whether the count is still inside the frame.
module spi_bit_index #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1,
    parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_lsbfe,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_in_frame
);

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

    logic [IDX_W-1:0] w_low;

    assign w_low = i_cnt[IDX_W-1:0];

    // Bit position: count itself for LSB-first, mirrored for MSB-first.
    always_comb begin
        o_in_frame = (i_cnt < CNT_END);
        if (i_lsbfe) begin
            o_idx = w_low;
        end else begin
            o_idx = IDX_MSB - w_low;
        end
    end

endmodule

// File: rtl/spi_shift_register.sv
// SPI serialiser/deserialiser in the Pclk domain: shifts a loaded word out on
// mosi and assembles miso bits, driven by single-cycle edge strobes.
module spi_shift_register
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  Pclk,
    input  logic                  PRESET_n,
    input  logic                  ss,
    input  logic                  send_data,
    input  logic [DATA_WIDTH-1:0] data_mosi,
    input  logic                  lsbfe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  mosi_send_sclk,
    input  logic                  mosi_send_sclk0,
    input  logic                  miso_recieve_sclk,
    input  logic                  miso_recieve_sclk0,
    input  logic                  miso,
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] data_miso,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int               IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_shift_reg;
    logic [DATA_WIDTH-1:0] r_rx_temp;
    logic [DATA_WIDTH-1:0] r_data_miso;
    logic [DATA_WIDTH-1:0] w_rx_word;
    logic [CNT_W-1:0]      r_tx_cnt;
    logic [CNT_W-1:0]      r_rx_cnt;
    logic                  r_sel;
    logic                  r_lsbfe;
    logic                  r_mosi;
    logic                  r_rx_valid;
    logic                  r_busy;
    logic [IDX_W-1:0]      w_tx_idx;
    logic [IDX_W-1:0]      w_rx_idx;
    logic                  w_tx_in_frame;
    logic                  w_rx_in_frame;
    logic                  w_tx_stb;
    logic                  w_rx_stb;
    logic                  w_load;
    logic                  w_abort;
    logic                  w_tx_fire;
    logic                  w_rx_fire;
    logic                  w_rx_last;

    spi_bit_index #(.DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_tx_index (
        .i_cnt      (r_tx_cnt),
        .i_lsbfe    (r_lsbfe),
        .o_idx      (w_tx_idx),
        .o_in_frame (w_tx_in_frame)
    );

    spi_bit_index #(.DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_rx_index (
        .i_cnt      (r_rx_cnt),
        .i_lsbfe    (r_lsbfe),
        .o_idx      (w_rx_idx),
        .o_in_frame (w_rx_in_frame)
    );

    assign w_tx_stb = pick_strobe(r_sel, mosi_send_sclk, mosi_send_sclk0);
    assign w_rx_stb = pick_strobe(r_sel, miso_recieve_sclk, miso_recieve_sclk0);

    // Frame state register.
    always_ff @(posedge Pclk) begin
        if (!PRESET_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (send_data) w_next_state = LOADED;
                else           w_next_state = IDLE;
            end
            LOADED: begin
                if (!ss) w_next_state = SHIFT;
                else     w_next_state = LOADED;
            end
            SHIFT: begin
                if (ss)             w_next_state = IDLE;
                else if (w_rx_last) w_next_state = IDLE;
                else                w_next_state = SHIFT;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Per-state datapath enables; strobes only count inside an active frame.
    always_comb begin
        w_load    = 1'b0;
        w_abort   = 1'b0;
        w_tx_fire = 1'b0;
        w_rx_fire = 1'b0;
        w_rx_last = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = send_data;
            end
            LOADED: begin
                w_load = 1'b0;
            end
            SHIFT: begin
                if (ss) begin
                    w_abort = 1'b1;
                end else begin
                    w_tx_fire = w_tx_stb && w_tx_in_frame;
                    w_rx_fire = w_rx_stb && w_rx_in_frame;
                    w_rx_last = w_rx_fire && (r_rx_cnt == CNT_LAST);
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Received word with the current miso bit merged in, so the final bit
    // lands in data_miso on the same edge that completes the frame.
    always_comb begin
        w_rx_word           = r_rx_temp;
        w_rx_word[w_rx_idx] = miso;
    end

    // Shift, receive and completion registers.
    always_ff @(posedge Pclk) begin
        if (!PRESET_n) begin
            r_shift_reg <= '0;
            r_rx_temp   <= '0;
            r_data_miso <= '0;
            r_tx_cnt    <= CNT_ZERO;
            r_rx_cnt    <= CNT_ZERO;
            r_sel       <= SEL_SCLK0;
            r_lsbfe     <= 1'b0;
            r_mosi      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_load) begin
                r_shift_reg <= data_mosi;
                r_rx_temp   <= '0;
                r_sel       <= cpol ^ cpha;
                r_lsbfe     <= lsbfe;
                r_busy      <= 1'b1;
                r_tx_cnt    <= CNT_ZERO;
                r_rx_cnt    <= CNT_ZERO;
            end else if (w_abort) begin
                r_busy   <= 1'b0;
                r_tx_cnt <= CNT_ZERO;
                r_rx_cnt <= CNT_ZERO;
            end else begin
                if (w_tx_fire) begin
                    r_mosi   <= r_shift_reg[w_tx_idx];
                    r_tx_cnt <= r_tx_cnt + CNT_ONE;
                end
                if (w_rx_last) begin
                    r_rx_temp   <= w_rx_word;
                    r_data_miso <= w_rx_word;
                    r_rx_valid  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_tx_cnt    <= CNT_ZERO;
                    r_rx_cnt    <= CNT_ZERO;
                end else if (w_rx_fire) begin
                    r_rx_temp <= w_rx_word;
                    r_rx_cnt  <= r_rx_cnt + CNT_ONE;
                end
            end
        end
    end

    assign mosi      = r_mosi;
    assign data_miso = r_data_miso;
    assign rx_valid  = r_rx_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_spi_shift_register.sv
// Directed bench for spi_shift_register: expected received words are queued
// at stimulus time and compared by an independent rx_valid monitor.
module tb_spi_shift_register;

    logic       Pclk;
    logic       PRESET_n;
    logic       ss;
    logic       send_data;
    logic [7:0] data_mosi;
    logic       lsbfe;
    logic       cpol;
    logic       cpha;
    logic       mosi_send_sclk;
    logic       mosi_send_sclk0;
    logic       miso_recieve_sclk;
    logic       miso_recieve_sclk0;
    logic       miso_w;
    logic       miso_drv;
    logic       loop;
    logic       mosi;
    logic [7:0] data_miso;
    logic       rx_valid;
    logic       busy;

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;

    assign miso_w = loop ? mosi : miso_drv;

    spi_shift_register #(.DATA_WIDTH(8)) dut (
        .Pclk               (Pclk),
        .PRESET_n           (PRESET_n),
        .ss                 (ss),
        .send_data          (send_data),
        .data_mosi          (data_mosi),
        .lsbfe              (lsbfe),
        .cpol               (cpol),
        .cpha               (cpha),
        .mosi_send_sclk     (mosi_send_sclk),
        .mosi_send_sclk0    (mosi_send_sclk0),
        .miso_recieve_sclk  (miso_recieve_sclk),
        .miso_recieve_sclk0 (miso_recieve_sclk0),
        .miso               (miso_w),
        .mosi               (mosi),
        .data_miso          (data_miso),
        .rx_valid           (rx_valid),
        .busy               (busy)
    );

    initial begin
        Pclk = 1'b0;
        forever #5 Pclk = ~Pclk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest queued word.
    always @(negedge Pclk) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rx_valid actual=%0h expected=none", data_miso);
            end else begin
                exp_word = exp_q.pop_front();
                check("rx_word", 16'(data_miso), 16'(exp_word));
            end
        end
    end

    task automatic clear_strobes();
        mosi_send_sclk     = 1'b0;
        mosi_send_sclk0    = 1'b0;
        miso_recieve_sclk  = 1'b0;
        miso_recieve_sclk0 = 1'b0;
    endtask

    // One tx strobe cycle then one rx strobe cycle; noise drives the
    // unselected pair at the same time.
    task automatic do_bit(input logic use_sclk, input logic exp_bit, input logic rx_bit,
                          input logic noise, input string tag);
        if (use_sclk) mosi_send_sclk = 1'b1; else mosi_send_sclk0 = 1'b1;
        if (noise) begin
            if (use_sclk) miso_recieve_sclk0 = 1'b1; else miso_recieve_sclk = 1'b1;
        end
        @(negedge Pclk);
        clear_strobes();
        check({tag, "_mosi"}, 16'(mosi), 16'(exp_bit));
        miso_drv = rx_bit;
        if (use_sclk) miso_recieve_sclk = 1'b1; else miso_recieve_sclk0 = 1'b1;
        if (noise) begin
            if (use_sclk) mosi_send_sclk0 = 1'b1; else mosi_send_sclk = 1'b1;
        end
        @(negedge Pclk);
        clear_strobes();
    endtask

    task automatic run_frame(input logic [7:0] word, input logic lsb, input logic pol, input logic pha,
                             input logic [7:0] rx_word, input logic lp, input logic noise,
                             input int nbits, input logic collide, input string tag);
        logic use_sclk;
        int   idx;
        use_sclk  = pol ^ pha;
        cpol      = pol;
        cpha      = pha;
        lsbfe     = lsb;
        loop      = lp;
        data_mosi = word;
        send_data = 1'b1;
        ss        = 1'b1;
        @(negedge Pclk);
        send_data = 1'b0;
        data_mosi = 8'h00;
        check({tag, "_busy_load"}, 16'(busy), 16'h0001);
        if (collide) begin
            send_data = 1'b1;
            data_mosi = 8'hFF;
        end
        ss = 1'b0;
        @(negedge Pclk);
        send_data = 1'b0;
        if (nbits == 8) exp_q.push_back(lp ? word : rx_word);
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : 7 - i;
            if (collide && i == 2) begin
                cpha      = ~cpha;
                lsbfe     = ~lsbfe;
                send_data = 1'b1;
                data_mosi = 8'hFF;
            end
            do_bit(use_sclk, word[idx], rx_word[idx], noise, tag);
            send_data = 1'b0;
        end
        if (nbits == 8) begin
            check({tag, "_busy_done"}, 16'(busy), 16'h0000);
            @(negedge Pclk);
            check({tag, "_rx_valid_1cyc"}, 16'(rx_valid), 16'h0000);
            check({tag, "_mosi_hold"}, 16'(mosi), 16'(word[lsb ? 7 : 0]));
            ss = 1'b1;
            @(negedge Pclk);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        PRESET_n  = 1'b0;
        ss        = 1'b1;
        send_data = 1'b0;
        data_mosi = 8'h00;
        lsbfe     = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        miso_drv  = 1'b0;
        loop      = 1'b0;
        clear_strobes();

        // Reset, then idle with ss high and random-looking strobes.
        @(negedge Pclk);
        PRESET_n = 1'b1;
        check("rst_mosi", 16'(mosi), 16'h0000);
        check("rst_data_miso", 16'(data_miso), 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        check("rst_rx_valid", 16'(rx_valid), 16'h0000);
        miso_drv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            {mosi_send_sclk, mosi_send_sclk0, miso_recieve_sclk, miso_recieve_sclk0} = 4'(i);
            @(negedge Pclk);
        end
        clear_strobes();
        check("idle_mosi", 16'(mosi), 16'h0000);
        check("idle_data_miso", 16'(data_miso), 16'h0000);
        check("idle_busy", 16'(busy), 16'h0000);

        // Mode 0, MSB-first loopback of A5.
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8, 1'b0, "m0");

        // Mode 1, LSB-first 3C out, C3 in, sclk0 strobes as noise.
        run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8, 1'b0, "m1");
        check("m1_data_miso", 16'(data_miso), 16'h00C3);

        // Abort after four rx strobes.
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0, "ab");
        ss = 1'b1;
        @(negedge Pclk);
        check("abort_busy", 16'(busy), 16'h0000);
        check("abort_rx_valid", 16'(rx_valid), 16'h0000);
        check("abort_data_miso", 16'(data_miso), 16'h00C3);
        check("abort_mosi_hold", 16'(mosi), 16'h0000);
        run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8, 1'b0, "post_ab");

        // Load and mode/bit-order changes while busy are ignored.
        run_frame(8'h96, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8, 1'b1, "coll");

        // Reset mid-frame clears every output.
        run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, "rstmid");
        PRESET_n = 1'b0;
        @(negedge Pclk);
        PRESET_n = 1'b1;
        ss       = 1'b1;
        check("rstmid_mosi", 16'(mosi), 16'h0000);
        check("rstmid_data_miso", 16'(data_miso), 16'h0000);
        check("rstmid_busy", 16'(busy), 16'h0000);
        check("rstmid_rx_valid", 16'(rx_valid), 16'h0000);
        @(negedge Pclk);

        // Mode 3 (sclk0 pair), LSB-first, after recovering from reset.
        run_frame(8'h81, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b1, 8, 1'b0, "m3");

        repeat (3) @(negedge Pclk);
        check("queue_empty", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
